// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, FSM state type and the rotate helper for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Rotate right by s so that bit s of the input lands at bit 0.
  function automatic logic [N_REQ-1:0] rotr(input logic [N_REQ-1:0] v,
                                            input logic [ID_W-1:0]  s);
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v} >> s;
    return dbl[N_REQ-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter8_prio_enc8.sv
// 8-to-3 priority encoder: index of the lowest set bit, plus a found flag.
module prio_enc8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scanning downward lets the lowest set bit overwrite any higher one.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = ID_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with grant hold and bounded tenure under contention.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [3:0]       hold_cnt, hold_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [ID_W-1:0]  id_nxt;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] cand_rot;
  logic [ID_W-1:0]  rot_idx;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             owner_req;
  logic             grant_new;

  // The current owner is never a candidate, so a preempt or release always moves on.
  assign cand      = (state == ST_GRANT) ? (req & ~gnt) : req;
  assign cand_rot  = rotr(cand, ptr);
  assign winner    = rot_idx + ptr;
  assign owner_req = |(req & gnt);
  assign gnt_valid = |gnt;

  prio_enc8 u_enc (
    .vec   (cand_rot),
    .idx   (rot_idx),
    .found (found)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    grant_new = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (found) grant_new = 1'b1;
      end
      ST_GRANT: begin
        if (!owner_req) begin
          if (found) begin
            grant_new = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
            hold_nxt  = '0;
          end
        end else if (hold_cnt < HOLD_MAX) begin
          hold_nxt = hold_cnt + 4'd1;
        end else if (found) begin
          grant_new = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (grant_new) begin
      state_nxt = ST_GRANT;
      gnt_nxt   = N_REQ'(1) << winner;
      id_nxt    = winner;
      ptr_nxt   = winner + 3'd1;
      hold_nxt  = 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= id_nxt;
    end
  end

endmodule
